// File: rtl/burt_v_window_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : burt_v_window_sequencer_if
// Brief    : Pixel-in / window-out bundle for the vertical Burt window sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface burt_v_window_sequencer_if #(
    parameter int FP_WIDTH_REG  = 16,
    parameter int WINDOW_HEIGHT = 5
);
    logic [FP_WIDTH_REG-1:0]                     data_i;
    logic                                        valid_i;
    logic                                        ready_o;
    logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0]  window_o;
    logic [15:0]                                 col_o;
    logic [15:0]                                 row_o;
    logic                                        valid_o;
    logic                                        frame_done_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, window_o, col_o, row_o, valid_o, frame_done_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, window_o, col_o, row_o, valid_o, frame_done_o
    );
endinterface
`default_nettype wire

// File: rtl/burt_v_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : burt_v_window_sequencer
// Brief    : Turns a raster pixel stream into clamped 5x1 vertical windows.
// Revision : 1.0 - initial release
// ============================================================================
module burt_v_window_sequencer #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480,
    parameter int WINDOW_HEIGHT = 5
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    burt_v_window_sequencer_if.slave   bus
);

    localparam int          c_AW       = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [15:0] c_LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] c_LAST_ROW = 16'(IMAGE_HEIGHT - 1);

    generate
        if (WINDOW_HEIGHT != 5) begin : g_bad_window_height
            $error("burt_v_window_sequencer: WINDOW_HEIGHT must be 5");
        end
        if (IMAGE_WIDTH < 2 || IMAGE_WIDTH > 65535) begin : g_bad_image_width
            $error("burt_v_window_sequencer: IMAGE_WIDTH out of range 2..65535");
        end
        if (IMAGE_HEIGHT < 3 || IMAGE_HEIGHT > 65535) begin : g_bad_image_height
            $error("burt_v_window_sequencer: IMAGE_HEIGHT out of range 3..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                                     r_state;
    logic [15:0]                                r_in_col;
    logic [15:0]                                r_in_row;
    logic [15:0]                                r_fl_col;
    logic                                       r_fl_row;
    logic                                       r_ready;
    logic                                       r_valid;
    logic                                       r_frame_done;
    logic [15:0]                                r_col;
    logic [15:0]                                r_row;
    logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0] r_window;

    logic [FP_WIDTH_REG-1:0] r_lb1 [0:IMAGE_WIDTH-1];
    logic [FP_WIDTH_REG-1:0] r_lb2 [0:IMAGE_WIDTH-1];
    logic [FP_WIDTH_REG-1:0] r_lb3 [0:IMAGE_WIDTH-1];
    logic [FP_WIDTH_REG-1:0] r_lb4 [0:IMAGE_WIDTH-1];

    logic                                       w_accept;
    logic [c_AW-1:0]                            w_addr;
    logic [FP_WIDTH_REG-1:0]                    w_src [0:7];
    logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0] w_tap;
    int                                         w_newest;
    int                                         w_center;
    int                                         w_tap_row;
    int                                         w_tap_dist;

    assign w_accept = bus.valid_i & r_ready;
    assign w_addr   = (r_state == S_FLUSH) ? r_fl_col[c_AW-1:0] : r_in_col[c_AW-1:0];

    // w_src[d] is the row d lines above the newest available row; each tap
    // clamps its wanted row into the frame, then picks the matching distance.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_src[i] = '0;
        end
        w_tap      = '0;
        w_tap_row  = 0;
        w_tap_dist = 0;
        if (r_state == S_FLUSH) begin
            w_src[0] = r_lb1[w_addr];
            w_src[1] = r_lb2[w_addr];
            w_src[2] = r_lb3[w_addr];
            w_src[3] = r_lb4[w_addr];
            w_newest = IMAGE_HEIGHT - 1;
            w_center = IMAGE_HEIGHT - 2 + int'(r_fl_row);
        end else begin
            w_src[0] = bus.data_i;
            w_src[1] = r_lb1[w_addr];
            w_src[2] = r_lb2[w_addr];
            w_src[3] = r_lb3[w_addr];
            w_src[4] = r_lb4[w_addr];
            w_newest = int'(r_in_row);
            w_center = int'(r_in_row) - 2;
        end
        for (int j = 0; j < WINDOW_HEIGHT; j++) begin
            w_tap_row = w_center - 2 + j;
            if (w_tap_row < 0) begin
                w_tap_row = 0;
            end
            if (w_tap_row > IMAGE_HEIGHT - 1) begin
                w_tap_row = IMAGE_HEIGHT - 1;
            end
            w_tap_dist = w_newest - w_tap_row;
            w_tap[j]   = w_src[w_tap_dist[2:0]];
        end
    end

    // Line storage is deliberately not reset: clamping never reads a stale row.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_accept) begin
            r_lb1[w_addr] <= bus.data_i;
            r_lb2[w_addr] <= r_lb1[w_addr];
            r_lb3[w_addr] <= r_lb2[w_addr];
            r_lb4[w_addr] <= r_lb3[w_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_FILL;
            r_in_col     <= '0;
            r_in_row     <= '0;
            r_fl_col     <= '0;
            r_fl_row     <= 1'b0;
            r_ready      <= 1'b1;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_window     <= '0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_FILL, S_STREAM: begin
                    if (w_accept) begin
                        if (r_in_col == c_LAST_COL) begin
                            r_in_col <= '0;
                            r_in_row <= r_in_row + 16'd1;
                        end else begin
                            r_in_col <= r_in_col + 16'd1;
                        end
                        if (r_state == S_FILL) begin
                            if (r_in_col == c_LAST_COL && r_in_row == 16'd1) begin
                                r_state <= S_STREAM;
                            end
                        end else begin
                            r_valid  <= 1'b1;
                            r_window <= w_tap;
                            r_col    <= r_in_col;
                            r_row    <= 16'(w_center);
                            if (r_in_col == c_LAST_COL && r_in_row == c_LAST_ROW) begin
                                r_state  <= S_FLUSH;
                                r_ready  <= 1'b0;
                                r_in_col <= '0;
                                r_in_row <= '0;
                                r_fl_col <= '0;
                                r_fl_row <= 1'b0;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    r_valid  <= 1'b1;
                    r_window <= w_tap;
                    r_col    <= r_fl_col;
                    r_row    <= 16'(w_center);
                    if (r_fl_col == c_LAST_COL) begin
                        r_fl_col <= '0;
                        r_fl_row <= 1'b1;
                        if (r_fl_row) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_FILL;
                            r_ready      <= 1'b1;
                            r_fl_row     <= 1'b0;
                        end
                    end else begin
                        r_fl_col <= r_fl_col + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o      = r_ready;
    assign bus.valid_o      = r_valid;
    assign bus.frame_done_o = r_frame_done;
    assign bus.col_o        = r_col;
    assign bus.row_o        = r_row;
    assign bus.window_o     = r_window;

endmodule
`default_nettype wire
